// File: rtl/cd_tx_frame_reader.sv
// CDBUS TX frame reader: reads one frame from the TX page RAM, hands its bytes to the
// serializer over a valid/ack handshake, appends or passes through the CRC, then releases the page.
module cd_tx_frame_reader #(
  parameter int ADDR_W    = 8,
  parameter int HDR_LEN   = 3,
  parameter int LEN_IDX   = 2,
  parameter int MAX_LEN   = 253,
  parameter int CRC_BYTES = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   user_crc,
  input  logic                   abort,
  output logic [7:0]             data,
  output logic                   has_data,
  input  logic                   ack_data,
  output logic                   is_crc_byte,
  output logic                   is_last_byte,
  input  logic [8*CRC_BYTES-1:0] crc_data,
  output logic                   len_err,
  input  logic                   ram_unread,
  input  logic [7:0]             ram_rd_byte,
  output logic [ADDR_W-1:0]      ram_rd_addr,
  output logic                   ram_rd_en,
  output logic                   ram_rd_done
);

  // state | meaning
  // IDLE  | wait for a frame in the page RAM
  // RD    | issue RAM read at the byte counter
  // LAT   | capture RAM byte (and the length byte)
  // HOLD  | present RAM byte until acked
  // CRC   | present live generated CRC byte until acked
  // DONE  | one-cycle page release pulse
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RD   = 3'd1;
  localparam logic [2:0] S_LAT  = 3'd2;
  localparam logic [2:0] S_HOLD = 3'd3;
  localparam logic [2:0] S_CRC  = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;

  localparam int         CNT_W     = ADDR_W + 1;
  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       len_q, len_d;
  logic [7:0]       data_q, data_d;
  logic             len_err_q, len_err_d;
  logic             ucrc_q, ucrc_d;

  logic [CNT_W-1:0] pay_end, ram_end, last_idx, crc_k, cnt_inc;
  logic             in_frame;

  always_comb begin
    pay_end  = CNT_W'(HDR_LEN) + CNT_W'(len_q);
    ram_end  = pay_end + (ucrc_q ? CNT_W'(CRC_BYTES) : '0);
    last_idx = pay_end + CNT_W'(CRC_BYTES - 1);
    crc_k    = cnt_q - pay_end;
    cnt_inc  = cnt_q + CNT_W'(1);
    in_frame = (state_q == S_RD) || (state_q == S_LAT) ||
               (state_q == S_HOLD) || (state_q == S_CRC);
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    len_d     = len_q;
    data_d    = data_q;
    len_err_d = len_err_q;
    ucrc_d    = ucrc_q;
    case (state_q)
      S_IDLE: begin
        if (ram_unread) begin
          if (abort) begin
            state_d = S_DONE;
          end else begin
            state_d   = S_RD;
            cnt_d     = '0;
            len_d     = '0;
            len_err_d = 1'b0;
            ucrc_d    = user_crc;
          end
        end
      end
      S_RD: state_d = S_LAT;
      S_LAT: begin
        data_d = ram_rd_byte;
        if (cnt_q == CNT_W'(LEN_IDX)) begin
          if (ram_rd_byte > MAX_LEN_B) begin
            len_d     = MAX_LEN_B;
            len_err_d = 1'b1;
          end else begin
            len_d = ram_rd_byte;
          end
        end
        state_d = S_HOLD;
      end
      S_HOLD: begin
        if (ack_data) begin
          cnt_d = cnt_inc;
          if (cnt_inc < ram_end) state_d = S_RD;
          else if (!ucrc_q)      state_d = S_CRC;
          else                   state_d = S_DONE;
        end
      end
      S_CRC: begin
        if (ack_data) begin
          cnt_d = cnt_inc;
          if (cnt_q == last_idx) state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // A vanished page leaves nothing to release, so it wins over abort.
    if (in_frame) begin
      if (!ram_unread) state_d = S_IDLE;
      else if (abort)  state_d = S_DONE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      len_q     <= '0;
      data_q    <= '0;
      len_err_q <= 1'b0;
      ucrc_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      len_q     <= len_d;
      data_q    <= data_d;
      len_err_q <= len_err_d;
      ucrc_q    <= ucrc_d;
    end
  end

  always_comb begin
    data = data_q;
    if (state_q == S_CRC) begin
      for (int i = 0; i < CRC_BYTES; i++) begin
        if (crc_k == CNT_W'(i)) data = crc_data[8*i +: 8];
      end
    end
  end

  assign has_data     = (state_q == S_HOLD) || (state_q == S_CRC);
  assign is_crc_byte  = has_data && (cnt_q >= pay_end);
  assign is_last_byte = has_data && (cnt_q == last_idx);
  assign len_err      = len_err_q;
  assign ram_rd_addr  = cnt_q[ADDR_W-1:0];
  assign ram_rd_en    = (state_q == S_RD);
  assign ram_rd_done  = (state_q == S_DONE);

endmodule

// File: tb/tb_cd_tx_frame_reader.sv
// Bench for cd_tx_frame_reader: randomized frames checked against a byte-list model built
// from the frame rules, plus directed abort, page-drop and mid-frame reset cases.
module tb_cd_tx_frame_reader;
  localparam int ADDR_W = 8, HDR_LEN = 3, LEN_IDX = 2, MAX_LEN = 253, CRC_BYTES = 2;

  logic        clk = 1'b0, reset = 1'b1;
  logic        user_crc = 1'b0, abort = 1'b0, ack_data = 1'b0, ram_unread = 1'b0;
  logic [15:0] crc_data = '0;
  logic [7:0]  ram_rd_byte = '0;
  logic [7:0]  data;
  logic        has_data, is_crc_byte, is_last_byte, len_err, ram_rd_en, ram_rd_done;
  logic [ADDR_W-1:0] ram_rd_addr;

  logic [7:0] mem [256];
  int n_checks = 0, n_pass = 0, reads_cnt = 0, addr_bad = 0, done_cnt = 0;

  cd_tx_frame_reader #(.ADDR_W(ADDR_W), .HDR_LEN(HDR_LEN), .LEN_IDX(LEN_IDX),
                       .MAX_LEN(MAX_LEN), .CRC_BYTES(CRC_BYTES)) dut (
    .clk(clk), .reset(reset), .user_crc(user_crc), .abort(abort), .data(data),
    .has_data(has_data), .ack_data(ack_data), .is_crc_byte(is_crc_byte),
    .is_last_byte(is_last_byte), .crc_data(crc_data), .len_err(len_err),
    .ram_unread(ram_unread), .ram_rd_byte(ram_rd_byte), .ram_rd_addr(ram_rd_addr),
    .ram_rd_en(ram_rd_en), .ram_rd_done(ram_rd_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (ram_rd_en) ram_rd_byte <= mem[ram_rd_addr];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Advance to the next falling edge and log reads (must be sequential from 0) and done pulses.
  task automatic tick();
    @(negedge clk);
    if (ram_rd_en) begin
      if (ram_rd_addr != 8'(reads_cnt)) addr_bad++;
      reads_cnt++;
    end
    if (ram_rd_done) done_cnt++;
  endtask

  task automatic fill_mem(input logic [7:0] len_byte);
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    mem[LEN_IDX] = len_byte;
  endtask

  task automatic run_frame(input bit ucrc, input bit live, input int dmin, input int dmax);
    int eff, ram_n, tot, idx, gap, wait_n, dly, guard, exp_gap, k;
    bit done_seen;
    logic [7:0] lb, expb;
    lb    = mem[LEN_IDX];
    eff   = (lb > MAX_LEN) ? MAX_LEN : int'(lb);
    ram_n = HDR_LEN + eff + (ucrc ? CRC_BYTES : 0);
    tot   = HDR_LEN + eff + CRC_BYTES;
    user_crc = ucrc; abort = 1'b0; ack_data = 1'b0; ram_unread = 1'b1;
    reads_cnt = 0; addr_bad = 0; done_cnt = 0;
    idx = 0; gap = 0; wait_n = 0; guard = 0; done_seen = 0;
    dly = $urandom_range(dmax, dmin);
    while (!done_seen && guard < 3000) begin
      tick();
      guard++; gap++;
      if (ram_rd_done) begin
        check_eq("done_gap", gap, 1);
        done_seen = 1; ram_unread = 1'b0; ack_data = 1'b0;
      end else if (has_data) begin
        if (wait_n == 0) begin
          if (idx == 0) begin
            check_eq("start_lat", gap, 3);
            check_eq("len_err_clr", len_err, 0);
          end else begin
            exp_gap = (idx < ram_n) ? 3 : 1;
            check_eq("ack_gap", gap, exp_gap);
          end
        end
        if (!ucrc && idx >= HDR_LEN + eff) begin
          k = idx - HDR_LEN - eff;
          expb = crc_data[8*k +: 8];
        end else begin
          expb = mem[idx % 256];
        end
        check_eq("data", data, expb);
        check_eq("crc_flag", is_crc_byte, idx >= HDR_LEN + eff);
        check_eq("last_flag", is_last_byte, idx == tot - 1);
        if (wait_n >= dly) begin
          ack_data = 1'b1; idx++; wait_n = 0; gap = 0;
          dly = $urandom_range(dmax, dmin);
        end else begin
          ack_data = 1'b0; wait_n++;
        end
        if (live) crc_data = 16'($urandom);
      end else begin
        check_eq("flags_idle", {is_crc_byte, is_last_byte}, 0);
        ack_data = 1'($urandom_range(1, 0));
      end
    end
    check_eq("frame_timeout", done_seen, 1);
    check_eq("bytes_sent", idx, tot);
    check_eq("ram_reads", reads_cnt, ram_n);
    check_eq("addr_seq", addr_bad, 0);
    check_eq("len_err", len_err, lb > MAX_LEN);
    ack_data = 1'b0;
    repeat (4) tick();
    check_eq("done_once", done_cnt, 1);
    check_eq("no_reads_after", reads_cnt, ram_n);
  endtask

  initial begin
    bit hit;
    int idx;

    tick(); tick();
    check_eq("rst_data", data, 0);
    check_eq("rst_has_data", has_data, 0);
    check_eq("rst_crc_flag", is_crc_byte, 0);
    check_eq("rst_last_flag", is_last_byte, 0);
    check_eq("rst_len_err", len_err, 0);
    check_eq("rst_addr", ram_rd_addr, 0);
    check_eq("rst_rd_en", ram_rd_en, 0);
    check_eq("rst_done", ram_rd_done, 0);
    reset = 1'b0;
    tick();

    // Basic frame with slow acks and a fixed generated CRC.
    fill_mem(8'h02);
    mem[0] = 8'h01; mem[1] = 8'h02; mem[3] = 8'hAA; mem[4] = 8'hBB;
    crc_data = 16'h1234;
    run_frame(1'b0, 1'b0, 5, 5);

    // User CRC stored in RAM; crc_data churns but must be ignored.
    mem[5] = 8'h56; mem[6] = 8'h78;
    run_frame(1'b1, 1'b1, 0, 3);

    // Zero-length payload.
    fill_mem(8'h00);
    mem[0] = 8'h01; mem[1] = 8'h02;
    crc_data = 16'hBEEF;
    run_frame(1'b0, 1'b0, 0, 2);

    // Oversized length byte clamps to MAX_LEN and sets len_err.
    fill_mem(8'hFF);
    run_frame(1'b0, 1'b0, 0, 1);

    for (int f = 0; f < 10; f++) begin
      fill_mem(8'($urandom_range(12, 0)));
      crc_data = 16'($urandom);
      run_frame(1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), 0, 4);
    end

    // Abort in HOLD of byte 3 with a simultaneous ack; abort held into DONE and IDLE.
    fill_mem(8'h02);
    user_crc = 1'b0; ram_unread = 1'b1; reads_cnt = 0; done_cnt = 0; idx = 0; hit = 0;
    for (int g = 0; g < 100 && !hit; g++) begin
      tick();
      if (has_data) begin
        ack_data = 1'b1;
        if (idx == 3) begin abort = 1'b1; hit = 1; end
        idx++;
      end else begin
        ack_data = 1'b0;
      end
    end
    check_eq("abort_reached", hit, 1);
    tick();
    check_eq("abort_has_data", has_data, 0);
    check_eq("abort_done", ram_rd_done, 1);
    ram_unread = 1'b0; ack_data = 1'b0;
    repeat (3) tick();
    abort = 1'b0;
    repeat (2) tick();
    check_eq("abort_done_once", done_cnt, 1);
    check_eq("abort_reads", reads_cnt, 4);

    // Abort in IDLE with a frame pending discards it without reading.
    ram_unread = 1'b1; abort = 1'b1; reads_cnt = 0; done_cnt = 0;
    tick();
    check_eq("idle_abort_done", ram_rd_done, 1);
    ram_unread = 1'b0; abort = 1'b0;
    repeat (3) tick();
    check_eq("idle_abort_once", done_cnt, 1);
    check_eq("idle_abort_reads", reads_cnt, 0);

    // Page withdrawn while byte 2 is presented.
    fill_mem(8'h04);
    ram_unread = 1'b1; reads_cnt = 0; done_cnt = 0; idx = 0; hit = 0;
    for (int g = 0; g < 100 && !hit; g++) begin
      tick();
      if (has_data && idx == 2) begin
        ram_unread = 1'b0; ack_data = 1'b0; hit = 1;
      end else if (has_data) begin
        ack_data = 1'b1; idx++;
      end else begin
        ack_data = 1'b0;
      end
    end
    check_eq("drop_reached", hit, 1);
    tick();
    check_eq("drop_has_data", has_data, 0);
    repeat (3) tick();
    check_eq("drop_no_done", done_cnt, 0);
    check_eq("drop_reads", reads_cnt, 3);

    // Reset mid-frame on a second frame.
    ram_unread = 1'b1; done_cnt = 0; idx = 0; hit = 0;
    for (int g = 0; g < 100 && !hit; g++) begin
      tick();
      if (has_data && idx == 1) begin
        hit = 1;
      end else if (has_data) begin
        ack_data = 1'b1; idx++;
      end else begin
        ack_data = 1'b0;
      end
    end
    check_eq("rstmid_reached", hit, 1);
    reset = 1'b1; ack_data = 1'b0;
    #1;
    check_eq("rstmid_has_data", has_data, 0);
    check_eq("rstmid_data", data, 0);
    check_eq("rstmid_addr", ram_rd_addr, 0);
    check_eq("rstmid_rd_en", ram_rd_en, 0);
    ram_unread = 1'b0;
    tick();
    reset = 1'b0;
    repeat (3) tick();
    check_eq("rstmid_no_done", done_cnt, 0);

    // Next frame must restart from address 0.
    fill_mem(8'h03);
    crc_data = 16'($urandom);
    run_frame(1'b0, 1'b1, 0, 2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
